// File: rtl/cpu_core_param.sv
// Parametrised two-cycle accumulator-style CPU core: loadable program memory,
// general registers, data memory, zero/carry flags, conditional jumps and HALT.
module cpu_core_param #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_GPR    = 8,
  parameter int unsigned PROG_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 16,
  localparam int unsigned PC_W      = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] din,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [31:0]       prog_wdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [PC_W-1:0]   pc,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted
);

  localparam int unsigned GprAw  = $clog2(NUM_GPR);
  localparam int unsigned DmemAw = $clog2(DMEM_DEPTH);

  localparam logic [4:0] OpMov  = 5'd0;
  localparam logic [4:0] OpAdd  = 5'd1;
  localparam logic [4:0] OpSub  = 5'd2;
  localparam logic [4:0] OpAnd  = 5'd3;
  localparam logic [4:0] OpOr   = 5'd4;
  localparam logic [4:0] OpLdm  = 5'd5;
  localparam logic [4:0] OpStm  = 5'd6;
  localparam logic [4:0] OpIn   = 5'd7;
  localparam logic [4:0] OpOut  = 5'd8;
  localparam logic [4:0] OpJmp  = 5'd9;
  localparam logic [4:0] OpJz   = 5'd10;
  localparam logic [4:0] OpJc   = 5'd11;
  localparam logic [4:0] OpHalt = 5'd12;

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic              started_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q;
  logic [31:0]       prog_mem [PROG_DEPTH];
  logic [DATA_W-1:0] gpr_q    [NUM_GPR];
  logic [DATA_W-1:0] dmem_q   [DMEM_DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              zero_q, carry_q;

  // Decoded instruction fields
  logic [4:0]        opcode;
  logic [GprAw-1:0]  rd_idx, rs1_idx, rs2_idx;
  logic              imm_sel;
  logic [DATA_W-1:0] imm, op1, op2;
  logic [DmemAw-1:0] dmem_addr;
  logic [PC_W-1:0]   jmp_tgt;
  logic [DATA_W:0]   sum_w, diff_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, is_alu, jump_taken;
  logic              unused_ir;

  assign opcode    = ir_q[31:27];
  assign rd_idx    = ir_q[22 +: GprAw];
  assign rs1_idx   = ir_q[17 +: GprAw];
  assign rs2_idx   = ir_q[0 +: GprAw];
  assign imm_sel   = ir_q[16];
  assign imm       = DATA_W'(ir_q[15:0]);
  assign dmem_addr = ir_q[DmemAw-1:0];
  assign jmp_tgt   = ir_q[PC_W-1:0];
  assign op1       = gpr_q[rs1_idx];
  assign op2       = imm_sel ? imm : gpr_q[rs2_idx];
  assign sum_w     = {1'b0, op1} + {1'b0, op2};
  // Top bit of the widened difference is the borrow, i.e. op1 < op2
  assign diff_w    = {1'b0, op1} - {1'b0, op2};
  assign is_alu    = (opcode <= OpOr);
  assign unused_ir = ^ir_q;

  // ALU result and carry for the flag-setting opcodes
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OpMov: alu_res = op2;
      OpAdd: begin
        alu_res   = sum_w[DATA_W-1:0];
        alu_carry = sum_w[DATA_W];
      end
      OpSub: begin
        alu_res   = diff_w[DATA_W-1:0];
        alu_carry = diff_w[DATA_W];
      end
      OpAnd: alu_res = op1 & op2;
      OpOr:  alu_res = op1 | op2;
      default: ;
    endcase
  end

  // Next state and next pc
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    jump_taken = 1'b0;
    case (opcode)
      OpJmp:   jump_taken = 1'b1;
      OpJz:    jump_taken = zero_q;
      OpJc:    jump_taken = carry_q;
      default: ;
    endcase
    unique case (state_q)
      // The first edge out of reset is a dead cycle, so instruction i fetches at edge 2i+1
      StFetch: if (started_q) state_d = StExec;
      StExec: begin
        if (opcode == OpHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
          pc_d    = jump_taken ? jmp_tgt : pc_q + 1'b1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Program memory: no reset, writable at any time, read-before-write on fetch
  always_ff @(posedge clk) begin
    if (prog_we) prog_mem[prog_addr] <= prog_wdata;
  end

  // Architectural state update
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= StFetch;
      started_q    <= 1'b0;
      pc_q         <= '0;
      ir_q         <= '0;
      gpr_q        <= '{default: '0};
      dmem_q       <= '{default: '0};
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      started_q    <= 1'b1;
      dout_valid_q <= 1'b0;
      if (state_q == StFetch && started_q) ir_q <= prog_mem[pc_q];
      if (state_q == StExec) begin
        if (is_alu) begin
          gpr_q[rd_idx] <= alu_res;
          zero_q        <= (alu_res == '0);
          carry_q       <= alu_carry;
        end
        case (opcode)
          OpLdm: gpr_q[rd_idx] <= dmem_q[dmem_addr];
          OpStm: dmem_q[dmem_addr] <= op1;
          OpIn:  gpr_q[rd_idx] <= din;
          OpOut: begin
            dout_q       <= op1;
            dout_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign pc         = pc_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign halted     = (state_q == StHalt);

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param: default build plus an 8-bit/4-GPR build.
module tb_cpu_core_param;

  localparam int OpMov = 0, OpAdd = 1, OpSub = 2, OpAnd = 3, OpOr = 4, OpLdm = 5, OpStm = 6;
  localparam int OpIn = 7, OpOut = 8, OpJmp = 9, OpJz = 10, OpJc = 11, OpHalt = 12, OpNop = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst, prog_we, dout_valid, zero_flag, carry_flag, halted;
  logic [15:0] din, dout;
  logic [4:0]  prog_addr, pc;
  logic [31:0] prog_wdata;

  logic        rst8, prog8_we, dout8_valid, zero8, carry8, halted8;
  logic [7:0]  din8, dout8;
  logic [4:0]  prog8_addr, pc8;
  logic [31:0] prog8_wdata;

  cpu_core_param dut (
    .clk(clk), .sys_rst(sys_rst), .din(din), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dout(dout), .dout_valid(dout_valid), .pc(pc),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
  );

  cpu_core_param #(.DATA_W(8), .NUM_GPR(4)) dut8 (
    .clk(clk), .sys_rst(rst8), .din(din8), .prog_we(prog8_we), .prog_addr(prog8_addr),
    .prog_wdata(prog8_wdata), .dout(dout8), .dout_valid(dout8_valid), .pc(pc8),
    .zero_flag(zero8), .carry_flag(carry8), .halted(halted8)
  );

  typedef struct {
    int          edge_n;
    logic [15:0] val;
  } pulse_t;

  pulse_t      exp_q[$];
  pulse_t      obs_q[$];
  int          total = 0;
  int          bad = 0;
  int          edge_n = -1;
  logic [31:0] img [32];

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input bit isel, input int src2);
    logic [31:0] w;
    w        = '0;
    w[31:27] = op[4:0];
    w[26:22] = rd[4:0];
    w[21:17] = rs1[4:0];
    w[16]    = isel;
    w[15:0]  = src2[15:0];
    return w;
  endfunction

  function automatic pulse_t mk(input int e, input logic [15:0] v);
    pulse_t p;
    p.edge_n = e;
    p.val    = v;
    return p;
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = enc(OpNop, 0, 0, 0, 0);
  endtask

  task automatic img_add();
    clear_img();
    img[0] = enc(OpMov, 0, 0, 1, 5);
    img[1] = enc(OpMov, 1, 0, 1, 7);
    img[2] = enc(OpAdd, 2, 0, 0, 1);
    img[3] = enc(OpOut, 0, 2, 0, 0);
    img[4] = enc(OpHalt, 0, 0, 0, 0);
  endtask

  task automatic img_carry();
    clear_img();
    img[0] = enc(OpMov, 0, 0, 1, 'hFFFF);
    img[1] = enc(OpAdd, 1, 0, 1, 1);
    img[2] = enc(OpJc, 0, 0, 1, 5);
    img[3] = enc(OpOut, 0, 0, 0, 0);
    img[4] = enc(OpHalt, 0, 0, 0, 0);
    img[5] = enc(OpOut, 0, 1, 0, 0);
    img[6] = enc(OpHalt, 0, 0, 0, 0);
  endtask

  // Holds reset while writing all 32 program words, then releases it; next posedge is edge 0
  task automatic load_and_reset();
    sys_rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      prog_we    = 1'b1;
      prog_addr  = i[4:0];
      prog_wdata = img[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
    sys_rst = 1'b0;
    edge_n  = -1;
    exp_q.delete();
    obs_q.delete();
  endtask

  // Advance one edge and record any output pulse
  task automatic step();
    pulse_t p;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (dout_valid === 1'b1) begin
      p.edge_n = edge_n;
      p.val    = dout;
      obs_q.push_back(p);
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; din = '0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if (dout !== 16'h0 || dout_valid !== 1'b0) begin
      bad++; $display("FAIL reset_dout: got %h/%b want 0000/0", dout, dout_valid);
    end
    total++;
    if (pc !== 5'd0 || halted !== 1'b0) begin
      bad++; $display("FAIL reset_pc_halt: got pc=%0d halted=%b want 0/0", pc, halted);
    end
    total++;
    if (zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got z=%b c=%b want 0/0", zero_flag, carry_flag);
    end
    img_add();
    load_and_reset();
    step(); step();
    total++;
    if (pc !== 5'd0) begin bad++; $display("FAIL start_pc_edge1: got %0d want 0", pc); end
    step();
    total++;
    if (pc !== 5'd1) begin bad++; $display("FAIL start_pc_edge2: got %0d want 1", pc); end
  endtask

  task automatic test_add();
    pulse_t e, o;
    img_add();
    load_and_reset();
    exp_q.push_back(mk(8, 16'h000C));
    while (edge_n < 14) begin
      step();
      if (edge_n == 9) begin
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL add_early_halt: got %b want 0", halted); end
      end
      if (edge_n == 10) begin
        total++;
        if (halted !== 1'b1 || pc !== 5'd4) begin
          bad++; $display("FAIL add_halt: got halted=%b pc=%0d want 1/4", halted, pc);
        end
      end
    end
    total++;
    if (dout !== 16'h000C) begin bad++; $display("FAIL add_dout_hold: got %h want 000c", dout); end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL add_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL add_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  task automatic test_alu();
    pulse_t e, o;
    clear_img();
    img[0]  = enc(OpMov, 0, 0, 1, 'h0F0F);
    img[1]  = enc(OpMov, 1, 0, 1, 'h00FF);
    img[2]  = enc(OpAnd, 2, 0, 0, 1);
    img[3]  = enc(OpOut, 0, 2, 0, 0);
    img[4]  = enc(OpOr, 3, 0, 0, 1);
    img[5]  = enc(OpOut, 0, 3, 0, 0);
    img[6]  = enc(OpSub, 4, 1, 0, 0);
    img[7]  = enc(OpOut, 0, 4, 0, 0);
    img[8]  = enc(OpJc, 0, 0, 1, 10);
    img[9]  = enc(OpOut, 0, 0, 0, 0);
    img[10] = enc(OpSub, 5, 1, 1, 'h00FF);
    img[11] = enc(OpJz, 0, 0, 1, 13);
    img[12] = enc(OpOut, 0, 0, 0, 0);
    img[13] = enc(OpOut, 0, 5, 0, 0);
    img[14] = enc(OpHalt, 0, 0, 0, 0);
    load_and_reset();
    exp_q.push_back(mk(8, 16'h000F));
    exp_q.push_back(mk(12, 16'h0FFF));
    exp_q.push_back(mk(16, 16'hF1F0));
    exp_q.push_back(mk(24, 16'h0000));
    while (edge_n < 28) begin
      step();
      if (edge_n == 16) begin
        total++;
        if (carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
          bad++; $display("FAIL alu_borrow: got z=%b c=%b want 0/1", zero_flag, carry_flag);
        end
      end
    end
    total++;
    if (halted !== 1'b1 || pc !== 5'd14 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      bad++; $display("FAIL alu_end: got h=%b pc=%0d z=%b c=%b want 1/14/1/0",
                      halted, pc, zero_flag, carry_flag);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL alu_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL alu_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  task automatic test_carry_zero();
    pulse_t e, o;
    img_carry();
    load_and_reset();
    exp_q.push_back(mk(8, 16'h0000));
    while (edge_n < 14) begin
      step();
      if (edge_n == 4) begin
        total++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
          bad++; $display("FAIL cz_flags: got z=%b c=%b want 1/1", zero_flag, carry_flag);
        end
      end
    end
    total++;
    if (halted !== 1'b1 || pc !== 5'd6) begin
      bad++; $display("FAIL cz_halt: got halted=%b pc=%0d want 1/6", halted, pc);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL cz_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL cz_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  task automatic test_mem_in();
    pulse_t e, o;
    logic [15:0] din_v [2];
    int          st_addr [2];
    din_v[0] = 16'h0001; st_addr[0] = 3;
    din_v[1] = 16'h5A3C; st_addr[1] = 19;
    for (int v = 0; v < 2; v++) begin
      clear_img();
      img[0] = enc(OpIn, 0, 0, 0, 0);
      img[1] = enc(OpStm, 0, 0, 1, st_addr[v]);
      img[2] = enc(OpAdd, 0, 0, 0, 0);
      img[3] = enc(OpLdm, 1, 0, 1, 3);
      img[4] = enc(OpOut, 0, 1, 0, 0);
      img[5] = enc(OpHalt, 0, 0, 0, 0);
      din = din_v[v];
      load_and_reset();
      exp_q.push_back(mk(10, din_v[v]));
      run_to(14);
      total++;
      if (obs_q.size() != exp_q.size()) begin
        bad++; $display("FAIL mem_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
        if (o.edge_n != e.edge_n || o.val !== e.val) begin
          bad++; $display("FAIL mem_pulse addr %0d: got edge %0d val %h want edge %0d val %h",
                          st_addr[v], o.edge_n, o.val, e.edge_n, e.val);
        end
      end
    end
  endtask

  task automatic test_param();
    pulse_t e, o, p;
    logic [31:0] w8 [4];
    int          e8;
    w8[0] = enc(OpMov, 5, 0, 1, 'h01FF);
    w8[1] = enc(OpAdd, 1, 1, 1, 1);
    w8[2] = enc(OpOut, 0, 1, 0, 0);
    w8[3] = enc(OpHalt, 0, 0, 0, 0);
    exp_q.delete(); obs_q.delete();
    rst8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prog8_we = 1'b1; prog8_addr = i[4:0]; prog8_wdata = w8[i];
    end
    @(negedge clk);
    prog8_we = 1'b0; rst8 = 1'b0; e8 = -1;
    exp_q.push_back(mk(6, 16'h0000));
    while (e8 < 10) begin
      @(posedge clk);
      e8++;
      @(negedge clk);
      if (dout8_valid === 1'b1) begin
        p.edge_n = e8; p.val = {8'h00, dout8}; obs_q.push_back(p);
      end
    end
    total++;
    if (carry8 !== 1'b1 || zero8 !== 1'b1 || halted8 !== 1'b1) begin
      bad++; $display("FAIL param_flags: got c=%b z=%b h=%b want 1/1/1", carry8, zero8, halted8);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL param_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL param_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  task automatic test_pc_wrap();
    pulse_t e, o;
    clear_img();
    img[31] = enc(OpOut, 0, 0, 0, 0);
    load_and_reset();
    exp_q.push_back(mk(64, 16'h0000));
    exp_q.push_back(mk(128, 16'h0000));
    run_to(64);
    total++;
    if (pc !== 5'd0) begin bad++; $display("FAIL wrap_pc: got %0d want 0", pc); end
    run_to(131);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL wrap_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL wrap_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  // Overwrites word 3 on the very edge that fetches it; the fetch must see the old word
  task automatic test_read_before_write();
    pulse_t e, o;
    img_add();
    load_and_reset();
    exp_q.push_back(mk(8, 16'h000C));
    run_to(6);
    prog_we = 1'b1; prog_addr = 5'd3; prog_wdata = enc(OpOut, 0, 0, 0, 0);
    step();
    prog_we = 1'b0;
    run_to(12);
    sys_rst = 1'b1;
    repeat (2) step();
    total++;
    if (dout !== 16'h0) begin bad++; $display("FAIL rbw_dout_reset: got %h want 0000", dout); end
    sys_rst = 1'b0;
    edge_n  = -1;
    // Second run uses the rewritten word 3 (OUT R0), since reset keeps program memory
    exp_q.push_back(mk(8, 16'h0005));
    run_to(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rbw_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL rbw_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_t e, o;
    img_carry();
    load_and_reset();
    run_to(7);
    sys_rst = 1'b1;
    step();
    total++;
    if (obs_q.size() != 0 || dout_valid !== 1'b0 || dout !== 16'h0) begin
      bad++; $display("FAIL mid_no_pulse: got n=%0d v=%b d=%h want 0/0/0000",
                      obs_q.size(), dout_valid, dout);
    end
    total++;
    if (pc !== 5'd0 || halted !== 1'b0 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      bad++; $display("FAIL mid_reset_state: got pc=%0d h=%b z=%b c=%b want 0/0/0/0",
                      pc, halted, zero_flag, carry_flag);
    end
    sys_rst = 1'b0;
    edge_n  = -1;
    obs_q.delete();
    exp_q.push_back(mk(8, 16'h0000));
    run_to(14);
    total++;
    if (halted !== 1'b1 || pc !== 5'd6 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
      bad++; $display("FAIL mid_rerun_end: got h=%b pc=%0d z=%b c=%b want 1/6/1/1",
                      halted, pc, zero_flag, carry_flag);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("FAIL mid_pulse_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o.edge_n != e.edge_n || o.val !== e.val) begin
        bad++; $display("FAIL mid_pulse: got edge %0d val %h want edge %0d val %h",
                        o.edge_n, o.val, e.edge_n, e.val);
      end
    end
  endtask

  initial begin
    rst8 = 1'b1; din8 = '0; prog8_we = 1'b0; prog8_addr = '0; prog8_wdata = '0;
    test_reset();
    test_add();
    test_alu();
    test_carry_zero();
    test_mem_in();
    test_param();
    test_pc_wrap();
    test_read_before_write();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_core_param.md
# cpu_core_param

Parametrised multi-cycle accumulator CPU core: the next-generation `top` with configurable data width, register count, program depth and data-memory depth. It adds a loadable program memory, zero/carry flags, conditional jumps and a HALT state. It executes one instruction every two clocks, reads `din` via IN and drives `dout` via OUT. It sits directly under the system testbench, in place of the fixed 16-bit core.

## Interface
- `DATA_W`, 16: GPR, data-memory, `din` and `dout` width (8..32).
- `NUM_GPR`, 8: general registers, power of 2, 2..32.
- `PROG_DEPTH`, 32: program words, power of 2; `PC_W = $clog2(PROG_DEPTH)`.
- `DMEM_DEPTH`, 16: data words, power of 2.

- `clk` in 1: single clock, rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `din` in DATA_W: input port, sampled by IN.
- `prog_we` in 1: program-memory write strobe.
- `prog_addr` in PC_W: program write address.
- `prog_wdata` in 32: instruction word.
- `dout` out DATA_W: output register, written by OUT.
- `dout_valid` out 1: one-cycle pulse on the edge that updates `dout`.
- `pc` out PC_W: current program counter.
- `zero_flag`, `carry_flag` out 1: ALU flags.
- `halted` out 1: core is in HALT.

## Operation
- Instruction fields:
  - [31:27] opcode.
  - [26:22] rd.
  - [21:17] rs1.
  - [16] imm_sel.
  - [15:0] src2: rs2 index in [4:0], or an immediate.
- Register indices use their low `$clog2(NUM_GPR)` bits.
- The immediate is zero-extended, or truncated, to DATA_W.
- `op2 = imm_sel ? imm : R[rs2]`.
- Opcodes:
  - 0 MOV: `rd = op2`.
  - 1 ADD: `rd = rs1 + op2`.
  - 2 SUB: `rd = rs1 - op2`.
  - 3 AND, 4 OR: bitwise on rs1 and op2.
  - 5 LDM: `rd = dmem[imm mod DMEM_DEPTH]`.
  - 6 STM: `dmem[imm mod DMEM_DEPTH] = R[rs1]`.
  - 7 IN: `rd = din`.
  - 8 OUT: `dout = R[rs1]`, pulse `dout_valid`.
  - 9 JMP: `pc = imm mod PROG_DEPTH`.
  - 10 JZ, 11 JC: jump if `zero_flag` / `carry_flag` is 1.
  - 12 HALT.
  - 13-31: NOP.
- Flags are updated only by opcodes 0-4:
  - zero = (result == 0).
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: carry = borrow (rs1 < op2).
  - MOV, AND, OR: carry = 0.
- Arithmetic wraps modulo 2^DATA_W.
- State machine: FETCH -> EXEC -> FETCH; HALT is absorbing.
  - FETCH: IR <= prog[pc].
  - EXEC: perform the operation; then pc <= jump target if the jump is taken, else pc+1.
  - pc wraps from PROG_DEPTH-1 to 0.
  - EXEC of HALT: state <= HALT, pc unchanged.
- Program memory is not cleared by reset. Writes via `prog_we` are accepted in every state, including during reset.
  - A write and a fetch to the same address in the same cycle: the fetch returns the old word (read-before-write).
- Reset values: state FETCH, pc 0, IR 0, all GPRs 0, all dmem 0, `dout` 0, `dout_valid` 0, flags 0, `halted` 0.
- Reset mid-instruction: the next edge with `sys_rst`=1 discards the instruction. No partial register or memory write occurs on that edge.

## Timing
- Edge 0 is the first edge with `sys_rst` sampled low.
- Instruction i (straight-line code) is fetched at edge 2i+1 and executed at edge 2i+2.
- Results are visible after the execute edge. A following instruction sees them: no hazards.
- Taken jumps cost no extra cycles. The target is fetched on the edge after EXEC.
- `dout_valid` is high for exactly the cycle after an OUT execute edge.
- `halted` rises after the HALT execute edge and holds until reset. In HALT, `dout`, `pc` and the flags hold their values.
- IN samples `din` at the execute edge.

## Test plan
- Add program:
  - Program: MOV R0,#5; MOV R1,#7; ADD R2,R0,R1; OUT R2; HALT.
  - Load it during reset.
  - Required: `dout`=0x000C with `dout_valid` after edge 8; `halted`=1 after edge 10; `pc`=4; `dout` stays 0x000C.
- Carry/zero:
  - Program: MOV R0,#0xFFFF; ADD R1,R0,#1; JC 5; OUT R0; HALT; OUT R1; HALT.
  - Required: zero=1, carry=1; exactly one `dout_valid`, with `dout`=0x0000; `halted` with `pc`=6.
- Memory and input:
  - Program: `din`=1; IN R0; STM [3],R0; ADD R0,R0,R0; LDM R1,[3]; OUT R1.
  - Required: `dout`=0x0001.
  - Repeat with DMEM_DEPTH=16 and address 19; required: the same word is accessed as address 3.
- Parametrisation:
  - Build DATA_W=8, NUM_GPR=4.
  - Program: MOV R5,#0x1FF (decodes as R1, 0xFF); ADD R1,R1,#1; OUT R1.
  - Required: `dout`=0x00, carry=1.
- PC wrap:
  - PROG_DEPTH=32, all words NOP except word 31 = OUT R0.
  - Required: a pulse after edge 64; `pc` reads 0 afterwards, and a pulse every 64 cycles.
- Reset mid-run:
  - Assert `sys_rst` on the EXEC edge of an OUT.
  - Required: no `dout_valid`; all outputs return to reset values; the program reruns from `pc`=0 with identical results.
